// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the rv32i multicycle control unit.
//   state_e    : FSM state encoding, also exported on state_dbg_o
//   OP_*       : rv32i major opcodes (inst[6:0])
//   is_wait_st : true for states that wait on the memory ready handshake
package riscv_mc_pkg;

    typedef enum logic [4:0] {
        StF0    = 5'd0,
        StF1    = 5'd1,
        StF2    = 5'd2,
        StR     = 5'd3,
        StRi    = 5'd4,
        StS0    = 5'd5,
        StS1    = 5'd6,
        StS2    = 5'd7,
        StL0    = 5'd8,
        StL1    = 5'd9,
        StL2    = 5'd10,
        StB     = 5'd11,
        StJal   = 5'd12,
        StJalr  = 5'd13,
        StLui   = 5'd14,
        StAuipc = 5'd15,
        StFence = 5'd16,
        StHalt  = 5'd17,
        StIdle  = 5'd31
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RI    = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    function automatic logic is_wait_st(state_e s);
        return (s == StF1) || (s == StL1) || (s == StS2);
    endfunction

endpackage

// File: rtl/riscv_mc_wait_timer.sv
// Memory wait-state counter with timeout detect.
//   clk_i, rst_i : clock, async active-high reset
//   clear_i      : zero the counter (asserted when entering a wait state)
//   waiting_i    : FSM is in a wait state this cycle
//   ready_i      : memory completes this cycle
//   expired_o    : wait exhausted with no ready this cycle
module riscv_mc_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic waiting_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_WAIT_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (waiting_i && !ready_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the final allowed cycle still completes the access.
    assign expired_o = waiting_i && !ready_i && (cnt_q == CntMax);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle control unit for the rv32i core: fetch/decode/execute sequencing
// with a memory ready handshake, bounded waits and sticky halt traps.
//   clk_i, rst_i          : clock, async active-high reset
//   opcode_i              : inst[6:0], valid from F2 onward
//   mem_ready_i           : memory completes current access this cycle
//   *_we_o                : datapath write-enables
//   mem_re_o, mem_we_o    : memory read/write request
//   sel_pc_grg_o          : address source (0=PC, 1=ALU/GPR)
//   sel_mem_grg_o         : data register source (0=memory, 1=GPR)
//   halted_o, trap_*_o    : halt status and sticky cause
//   instret_o             : retired-instruction count
//   state_dbg_o           : current state encoding
// Optional: define FENCE_NOP_EN to execute FENCE as a no-op instead of trapping.
module riscv_mc_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned RET_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             addr_reg_we_o,
    output logic             data_reg_we_o,
    output logic             inst_reg_we_o,
    output logic             grg_we_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             sel_pc_grg_o,
    output logic             sel_mem_grg_o,
    output logic             halted_o,
    output logic             trap_illegal_o,
    output logic             trap_timeout_o,
    output logic [RET_W-1:0] instret_o,
    output logic [4:0]       state_dbg_o
);

    state_e           state_q, state_d;
    logic [RET_W-1:0] instret_q;
    logic             trap_ill_q, trap_to_q;
    logic             retire, set_ill, set_to;
    logic             waiting, wait_clear, expired;

    assign waiting    = is_wait_st(state_q);
    assign wait_clear = is_wait_st(state_d) && (state_d != state_q);

    riscv_mc_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (wait_clear),
        .waiting_i(waiting),
        .ready_i  (mem_ready_i),
        .expired_o(expired)
    );

    always_comb begin
        state_d       = state_q;
        pc_we_o       = 1'b0;
        addr_reg_we_o = 1'b0;
        data_reg_we_o = 1'b0;
        inst_reg_we_o = 1'b0;
        grg_we_o      = 1'b0;
        mem_re_o      = 1'b0;
        mem_we_o      = 1'b0;
        sel_pc_grg_o  = 1'b0;
        sel_mem_grg_o = 1'b0;
        halted_o      = 1'b0;
        retire        = 1'b0;
        set_ill       = 1'b0;
        set_to        = 1'b0;

        unique case (state_q)
            StIdle: state_d = StF0;
            StF0: begin
                addr_reg_we_o = 1'b1;
                state_d       = StF1;
            end
            StF1: begin
                mem_re_o      = 1'b1;
                data_reg_we_o = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = StF2;
                end else if (expired) begin
                    state_d = StHalt;
                    set_to  = 1'b1;
                end
            end
            StF2: begin
                inst_reg_we_o = 1'b1;
                case (opcode_i)
                    OP_R:     state_d = StR;
                    OP_RI:    state_d = StRi;
                    OP_S:     state_d = StS0;
                    OP_L:     state_d = StL0;
                    OP_B:     state_d = StB;
                    OP_JAL:   state_d = StJal;
                    OP_JALR:  state_d = StJalr;
                    OP_LUI:   state_d = StLui;
                    OP_AUIPC: state_d = StAuipc;
`ifdef FENCE_NOP_EN
                    OP_FENCE: state_d = StFence;
`endif
                    default: begin
                        state_d = StHalt;
                        set_ill = 1'b1;
                    end
                endcase
            end
            StR, StRi, StJal, StJalr, StLui, StAuipc: begin
                pc_we_o  = 1'b1;
                grg_we_o = 1'b1;
                retire   = 1'b1;
                state_d  = StF0;
            end
            StB, StFence: begin
                pc_we_o = 1'b1;
                retire  = 1'b1;
                state_d = StF0;
            end
            StL0, StS0: begin
                addr_reg_we_o = 1'b1;
                sel_pc_grg_o  = 1'b1;
                state_d       = (state_q == StL0) ? StL1 : StS1;
            end
            StL1: begin
                mem_re_o      = 1'b1;
                sel_pc_grg_o  = 1'b1;
                data_reg_we_o = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = StL2;
                end else if (expired) begin
                    state_d = StHalt;
                    set_to  = 1'b1;
                end
            end
            StL2: begin
                grg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                retire   = 1'b1;
                state_d  = StF0;
            end
            StS1: begin
                data_reg_we_o = 1'b1;
                sel_mem_grg_o = 1'b1;
                state_d       = StS2;
            end
            StS2: begin
                mem_we_o      = 1'b1;
                sel_pc_grg_o  = 1'b1;
                sel_mem_grg_o = 1'b1;
                pc_we_o       = mem_ready_i;
                retire        = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = StF0;
                end else if (expired) begin
                    state_d = StHalt;
                    set_to  = 1'b1;
                end
            end
            StHalt: halted_o = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            instret_q  <= '0;
            trap_ill_q <= 1'b0;
            trap_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + RET_W'(1);
            end
            if (set_ill) begin
                trap_ill_q <= 1'b1;
            end
            if (set_to) begin
                trap_to_q <= 1'b1;
            end
        end
    end

    assign instret_o      = instret_q;
    assign trap_illegal_o = trap_ill_q;
    assign trap_timeout_o = trap_to_q;
    assign state_dbg_o    = state_q;

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Second-generation multicycle control unit for the rv32i core. It sequences fetch, decode and execute for every rv32i major opcode and drives all datapath write-enables and operand selects.
- Unlike the first generation, it waits on a memory ready handshake instead of assuming fixed latency, bounds each wait with a timeout, and halts with a sticky trap on illegal opcode or timeout.
- Provides a retired-instruction counter and a state debug output.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles a memory access may wait for mem_ready before trapping (1..255).
- RET_W, 32, width of the instret counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  7  inst[6:0] from the instruction register, valid from F2 onward.
- mem_ready  in  1  memory completes the current read/write in this cycle.
- pc_we, addr_reg_we, data_reg_we, inst_reg_we, grg_we  out  1 each  datapath write-enables.
- mem_re, mem_we  out  1 each  memory read/write request.
- sel_pc_grg  out  1  address source: 0=PC, 1=ALU/GPR.
- sel_mem_grg  out  1  data register source: 0=memory, 1=GPR (store data).
- halted  out  1  core stopped.
- trap_illegal, trap_timeout  out  1 each  sticky halt cause.
- instret  out  RET_W  retired-instruction count.
- state_dbg  out  5  current state encoding.

Behaviour:
- State register updates on posedge clk. rst forces IDLE, clears instret, the wait counter and both trap flags, all immediately (asynchronous).
- Outputs are Moore, decoded combinationally from the current state, except the mem_ready-qualified terms noted below. In IDLE every output is 0.
- State encodings (state_dbg):
  - IDLE=31, F0=0, F1=1, F2=2, R=3, RI=4, S0=5, S1=6, S2=7, L0=8, L1=9, L2=10, B=11, JAL=12, JALR=13, LUI=14, AUIPC=15, FENCE=16, HALT=17.
- Transitions and outputs:
  - IDLE -> F0.
  - F0: addr_reg_we=1, sel_pc_grg=0. -> F1.
  - F1: mem_re=1. data_reg_we=mem_ready. -> F2 when mem_ready, else stay.
  - F2: inst_reg_we=1. Next state decoded from opcode:
    - 0110011 -> R; 0010011 -> RI; 0100011 -> S0; 0000011 -> L0; 1100011 -> B.
    - 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
    - Anything else -> HALT with trap_illegal set.
  - R, RI, JAL, JALR, LUI, AUIPC: pc_we=1, grg_we=1. -> F0.
  - B: pc_we=1, grg_we=0. -> F0.
  - L0: addr_reg_we=1, sel_pc_grg=1. -> L1.
  - L1: mem_re=1, sel_pc_grg=1, data_reg_we=mem_ready. -> L2 on mem_ready.
  - L2: grg_we=1, pc_we=1. -> F0.
  - S0: addr_reg_we=1, sel_pc_grg=1. -> S1.
  - S1: data_reg_we=1, sel_mem_grg=1. -> S2.
  - S2: mem_we=1, sel_pc_grg=1, sel_mem_grg=1, pc_we=mem_ready. -> F0 on mem_ready.
  - HALT: all enables 0, halted=1. Terminal until rst.
- Wait counter (wait states F1, L1, S2):
  - Width is ceil(log2(MEM_WAIT_MAX+1)). Clears on entry to any wait state.
  - Increments each cycle in a wait state with mem_ready=0.
  - If it equals MEM_WAIT_MAX with mem_ready=0 -> HALT, trap_timeout=1. mem_ready in that same cycle wins: the access completes with no trap.
- instret:
  - Increments by 1 in the last cycle of each instruction: R/RI/B/JAL/JALR/LUI/AUIPC/L2/FENCE, and S2 with mem_ready.
  - Wraps modulo 2^RET_W. Never increments on a trap.
- trap flags are mutually exclusive and hold until rst.
- mem_re and mem_we are never both 1.

Optional Feature:
- FENCE_NOP_EN defined: opcode 0001111 -> FENCE state (pc_we=1 only, counts as retired) -> F0.
- Not defined: 0001111 is illegal and halts with trap_illegal.

Decomposition:
- Package riscv_mc_pkg holds:
  - the state encoding constants;
  - the opcode constants (OP_R, OP_RI, OP_S, OP_L, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE).
- One natural sub-module, riscv_mc_wait_timer: the wait counter plus timeout compare. Inputs: clk, rst, clear, waiting, ready. Output: expired.

Test Plan:
- add (0110011), mem_ready tied 1 -> states 31,0,1,2,3,0. pc_we=grg_we=1 only in state 3. instret=1.
- lw with mem_ready delayed 3 cycles in both F1 and L1 -> F1 and L1 each held 4 cycles. data_reg_we=1 only in the ready cycle. grg_we in L2. instret=1.
- sw, mem_ready=1 -> S1 shows data_reg_we=1 and sel_mem_grg=1. S2 shows mem_we=1, pc_we=1. mem_re never 1 after F1.
- mem_ready held 0 in F1, MEM_WAIT_MAX=4 -> HALT after 5 cycles in F1. trap_timeout=1, halted=1, all enables 0, instret unchanged.
- opcode 1111111 -> HALT from F2, trap_illegal=1. With FENCE_NOP_EN, opcode 0001111 -> state 16, then F0, instret+1.
- Assert rst during L1 -> state_dbg=31 and enables 0 before the next clk edge. After release, refetch starts from F0.
